sdram_burst_sched: RTL and testbench
====================================

Name: sdram_burst_sched

Overview:
- Burst scheduler in front of the SDRAM state-machine controller.
- Watches write-FIFO occupancy and read-FIFO free space, and arbitrates round-robin between write and read bursts.
- Drives the controller's wr/rd request, burst-length and address inputs.
- Treats SDRAM as a ring buffer, with independent write and read pointers and a fill counter.

Parameters:
- BURST_LEN, 256, words per burst; 1..256; drives sdwr_byte/sdrd_byte.
- ADDR_W, 22, word-address width (bank+row+col).
- MEM_WORDS, 2**22, ring size in words; must be a multiple of BURST_LEN.
- FIFO_AW, 9, width of the FIFO occupancy inputs.
- RFIFO_DEPTH, 512, read-FIFO depth in words.
- WDT_CYC, 1023, watchdog limit in cycles (optional feature only).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous reset, active-low
- sdram_init_done  in  1  controller initialisation complete
- wfifo_used  in  FIFO_AW+1  words waiting in write FIFO
- rfifo_used  in  FIFO_AW+1  words held in read FIFO
- sdram_wr_ack  in  1  controller write-data strobe
- sdram_rd_ack  in  1  controller read-data strobe
- sdram_wr_req  out  1  write burst request
- sdram_rd_req  out  1  read burst request
- sdwr_byte  out  9  write burst length, constant BURST_LEN
- sdrd_byte  out  9  read burst length, constant BURST_LEN
- sys_wraddr  out  ADDR_W  start address of current/next write burst
- sys_rdaddr  out  ADDR_W  start address of current/next read burst
- fill_words  out  ADDR_W+1  words written and not yet read back
- sched_err  out  1  sticky watchdog error (0 when feature is out)

Behaviour:
- Reset: all outputs 0 except sdwr_byte/sdrd_byte = BURST_LEN.
  - State S_IDLE, last_grant = read (so write has first priority).
  - Reset mid-burst drops requests immediately. Pointers and fill return to 0.
- Ack registering: wr_ack_q/rd_ack_q are registered copies of the acks. Edges are detected on the registered copies only.
- Eligibility:
  - wr_ok = init_done & (wfifo_used >= BURST_LEN) & (fill_words <= MEM_WORDS-BURST_LEN).
  - rd_ok = init_done & (fill_words >= BURST_LEN) & (rfifo_used <= RFIFO_DEPTH-BURST_LEN).
- S_IDLE:
  - If both eligible, grant the opposite of last_grant. Otherwise grant whichever is eligible.
  - Next state is S_WREQ or S_RREQ; last_grant updates on the grant.
- S_WREQ: sdram_wr_req = 1, held until wr_ack_q rises, then go to S_WRUN with req = 0.
- S_WRUN: wait for wr_ack_q falling edge. On that edge:
  - sys_wraddr += BURST_LEN, wrapping to 0 at MEM_WORDS.
  - fill_words += BURST_LEN.
  - Then go to S_IDLE.
- S_RREQ / S_RRUN: same sequence using rd_ack_q, sys_rdaddr, and fill_words -= BURST_LEN.
- Request timing: requests are registered outputs asserted the cycle after the grant, so idle-to-req latency is 1 clk.
  - At least one idle cycle separates bursts.
- Addresses are stable from the grant until the falling ack edge.
- Full ring (fill_words = MEM_WORDS): writes blocked, reads allowed.
- Empty ring: reads blocked.
- Pointer wrap: a pointer exactly equal to MEM_WORDS-BURST_LEN wraps to 0.
- An ack edge while in S_IDLE is ignored.

Optional Feature:
- Macro SDRAM_SCHED_WDT_EN.
- With it defined:
  - A cycle counter runs in S_WREQ/S_RREQ/S_WRUN/S_RRUN.
  - If it reaches WDT_CYC, drop the request, leave pointers and fill unchanged, set sched_err (sticky until reset), and return to S_IDLE.
- Without it: no counter; sched_err is tied to 0.

Decomposition:
- Shared package/include sdram_sched_pkg: state encodings S_IDLE..S_RRUN, grant encoding, and BURST_LEN/ADDR_W defaults.
- One natural sub-module, sdram_ring_ptr, instantiated twice. It holds the address register with modulo-MEM_WORDS advance on an adv pulse.

Test Plan:
- Write then read: wfifo_used=256, rfifo_used=0 after init, controller model acks 256 cycles.
  - Expect wr_req, then sys_wraddr=256 and fill_words=256.
  - Next grant is a read at sys_rdaddr=0; afterwards fill_words=0.
- Init gating: wfifo_used=300 with init_done=0 -> no request for 1000 cycles. Request appears 2 cycles after init_done rises.
- Round-robin: wr_ok and rd_ok held continuously -> grants alternate W,R,W,R over 8 bursts. First grant is W after reset.
- Wrap: MEM_WORDS=1024, perform 4 write bursts -> sys_wraddr sequence 256,512,768,0.
  - A 5th write is blocked (fill_words=1024) until one read completes.
- Read backpressure: fill_words=512, rfifo_used=257 -> no rd_req. rfifo_used=256 -> rd_req within 2 cycles.
- Reset and watchdog:
  - Reset asserted during S_WRUN -> wr_req=0, pointers=0 immediately.
  - With SDRAM_SCHED_WDT_EN and no ack for 1023 cycles -> req drops, sched_err=1, sys_wraddr unchanged.

Source files
------------

// File: rtl/sdram_sched_pkg.sv
// Shared encodings and default sizes for the SDRAM burst scheduler.
package sdram_sched_pkg;

    localparam int unsigned BURST_LEN_DEF = 256;
    localparam int unsigned ADDR_W_DEF    = 22;
    localparam int unsigned BYTE_W        = 9;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WREQ = 3'd1,
        S_WRUN = 3'd2,
        S_RREQ = 3'd3,
        S_RRUN = 3'd4
    } sched_state_t;

    typedef enum logic {
        G_RD = 1'b0,
        G_WR = 1'b1
    } grant_t;

endpackage

// File: rtl/sdram_ring_ptr.sv
// Ring-buffer burst address: advances by one burst per adv pulse, modulo MEM_WORDS.
module sdram_ring_ptr #(
    parameter int unsigned ADDR_W    = 22,
    parameter int unsigned BURST_LEN = 256,
    parameter int unsigned MEM_WORDS = 2**22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] LAST_START = ADDR_W'(MEM_WORDS - BURST_LEN);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BURST_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (adv) begin
            addr <= (addr == LAST_START) ? '0 : addr + STEP;
        end
    end

endmodule

// File: rtl/sdram_burst_sched.sv
// Round-robin write/read burst scheduler treating SDRAM as a ring buffer.
// Optional watchdog on stuck bursts enabled by defining SDRAM_SCHED_WDT_EN.
module sdram_burst_sched
    import sdram_sched_pkg::*;
#(
    parameter int unsigned BURST_LEN   = BURST_LEN_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned MEM_WORDS   = 2**22,
    parameter int unsigned FIFO_AW     = 9,
    parameter int unsigned RFIFO_DEPTH = 512,
    parameter int unsigned WDT_CYC     = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sdram_init_done,
    input  logic [FIFO_AW:0]    wfifo_used,
    input  logic [FIFO_AW:0]    rfifo_used,
    input  logic                sdram_wr_ack,
    input  logic                sdram_rd_ack,
    output logic                sdram_wr_req,
    output logic                sdram_rd_req,
    output logic [BYTE_W-1:0]   sdwr_byte,
    output logic [BYTE_W-1:0]   sdrd_byte,
    output logic [ADDR_W-1:0]   sys_wraddr,
    output logic [ADDR_W-1:0]   sys_rdaddr,
    output logic [ADDR_W:0]     fill_words,
    output logic                sched_err
);

    localparam int unsigned FILL_W = ADDR_W + 1;
    localparam int unsigned USED_W = FIFO_AW + 1;

    // Elaboration-time parameter legality
    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst
        $error("BURST_LEN out of range");
    end
    if ((MEM_WORDS % BURST_LEN) != 0) begin : g_bad_ring
        $error("MEM_WORDS must be a multiple of BURST_LEN");
    end
    if (WDT_CYC == 0) begin : g_bad_wdt
        $error("WDT_CYC must be non-zero");
    end

    sched_state_t state_q, state_d;
    grant_t       last_q, last_d;
    logic wr_ack_q, wr_ack_q2, rd_ack_q, rd_ack_q2;
    logic wr_req_d, rd_req_d;
    logic wr_adv_c, rd_adv_c, abort_c;
    logic wr_ok_c, rd_ok_c;
    logic wr_rise_c, wr_fall_c, rd_rise_c, rd_fall_c;

    assign sdwr_byte = BYTE_W'(BURST_LEN);
    assign sdrd_byte = BYTE_W'(BURST_LEN);

    // Edges are taken only from the registered ack copies
    assign wr_rise_c =  wr_ack_q & ~wr_ack_q2;
    assign wr_fall_c = ~wr_ack_q &  wr_ack_q2;
    assign rd_rise_c =  rd_ack_q & ~rd_ack_q2;
    assign rd_fall_c = ~rd_ack_q &  rd_ack_q2;

    assign wr_ok_c = sdram_init_done
                   && (wfifo_used >= USED_W'(BURST_LEN))
                   && (fill_words <= FILL_W'(MEM_WORDS - BURST_LEN));
    assign rd_ok_c = sdram_init_done
                   && (fill_words >= FILL_W'(BURST_LEN))
                   && (rfifo_used <= USED_W'(RFIFO_DEPTH - BURST_LEN));

`ifdef SDRAM_SCHED_WDT_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYC + 1);
    logic [WDT_W-1:0] wdt_q;
    logic             err_q;

    assign abort_c   = (state_q != S_IDLE) && (wdt_q == WDT_W'(WDT_CYC));
    assign sched_err = err_q;

    // Busy-cycle watchdog; error stays set until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE || abort_c) wdt_q <= '0;
            else                              wdt_q <= wdt_q + WDT_W'(1);
            if (abort_c) err_q <= 1'b1;
        end
    end
`else
    assign abort_c   = 1'b0;
    assign sched_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_q       <= G_RD;
            wr_ack_q     <= 1'b0;
            wr_ack_q2    <= 1'b0;
            rd_ack_q     <= 1'b0;
            rd_ack_q2    <= 1'b0;
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            fill_words   <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            wr_ack_q     <= sdram_wr_ack;
            wr_ack_q2    <= wr_ack_q;
            rd_ack_q     <= sdram_rd_ack;
            rd_ack_q2    <= rd_ack_q;
            sdram_wr_req <= wr_req_d;
            sdram_rd_req <= rd_req_d;
            if (wr_adv_c)      fill_words <= fill_words + FILL_W'(BURST_LEN);
            else if (rd_adv_c) fill_words <= fill_words - FILL_W'(BURST_LEN);
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
        wr_adv_c = 1'b0;
        rd_adv_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Round-robin only matters when both sides are eligible
                if (wr_ok_c && (!rd_ok_c || last_q == G_RD)) begin
                    state_d = S_WREQ;
                    last_d  = G_WR;
                end else if (rd_ok_c) begin
                    state_d = S_RREQ;
                    last_d  = G_RD;
                end
            end
            S_WREQ: begin
                if (wr_rise_c) state_d  = S_WRUN;
                else           wr_req_d = 1'b1;
            end
            S_WRUN: begin
                if (wr_fall_c) begin
                    wr_adv_c = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_RREQ: begin
                if (rd_rise_c) state_d  = S_RRUN;
                else           rd_req_d = 1'b1;
            end
            S_RRUN: begin
                if (rd_fall_c) begin
                    rd_adv_c = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_c) begin
            state_d  = S_IDLE;
            wr_req_d = 1'b0;
            rd_req_d = 1'b0;
            wr_adv_c = 1'b0;
            rd_adv_c = 1'b0;
        end
    end

    sdram_ring_ptr #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .MEM_WORDS (MEM_WORDS)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (wr_adv_c),
        .addr  (sys_wraddr)
    );

    sdram_ring_ptr #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .MEM_WORDS (MEM_WORDS)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (rd_adv_c),
        .addr  (sys_rdaddr)
    );

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Scoreboard bench for sdram_burst_sched: ring model predicts each grant, monitor checks it.
module tb_sdram_burst_sched;

    localparam int unsigned B   = 16;
    localparam int unsigned AW  = 6;
    localparam int unsigned MW  = 64;
    localparam int unsigned FAW = 9;
    localparam int unsigned RD  = 64;
    localparam int unsigned THR = RD - B;
    localparam int unsigned UW  = FAW + 1;

    typedef struct {
        bit is_wr;
        int wa;
        int ra;
        int fill;
    } exp_t;

    logic          clk, rst_n, sdram_init_done, sdram_wr_ack, sdram_rd_ack;
    logic [FAW:0]  wfifo_used, rfifo_used;
    logic          sdram_wr_req, sdram_rd_req, sched_err;
    logic [8:0]    sdwr_byte, sdrd_byte;
    logic [AW-1:0] sys_wraddr, sys_rdaddr;
    logic [AW:0]   fill_words;

    int   n_checks, n_fail;
    exp_t exp_q[$];
    int   m_wp, m_rp, m_fill;
    bit   m_last_wr, m_init, pend;

    sdram_burst_sched #(
        .BURST_LEN   (B),
        .ADDR_W      (AW),
        .MEM_WORDS   (MW),
        .FIFO_AW     (FAW),
        .RFIFO_DEPTH (RD),
        .WDT_CYC     (1023)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .wfifo_used      (wfifo_used),
        .rfifo_used      (rfifo_used),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdwr_byte       (sdwr_byte),
        .sdrd_byte       (sdrd_byte),
        .sys_wraddr      (sys_wraddr),
        .sys_rdaddr      (sys_rdaddr),
        .fill_words      (fill_words),
        .sched_err       (sched_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Ring model: decide the next grant from occupancy rules and queue its expected view
    task automatic apply_vals(input int w, input int r);
        bit wr_ok, rd_ok, g;
        wfifo_used = UW'(w);
        rfifo_used = UW'(r);
        wr_ok = m_init && (w >= int'(B)) && (m_fill <= int'(MW - B));
        rd_ok = m_init && (m_fill >= int'(B)) && (r <= int'(THR));
        pend  = wr_ok || rd_ok;
        if (!pend) return;
        g = (wr_ok && rd_ok) ? !m_last_wr : wr_ok;
        exp_q.push_back('{g, m_wp, m_rp, m_fill});
        m_last_wr = g;
        if (g) begin
            m_wp   = (m_wp + int'(B)) % int'(MW);
            m_fill = m_fill + int'(B);
        end else begin
            m_rp   = (m_rp + int'(B)) % int'(MW);
            m_fill = m_fill - int'(B);
        end
    endtask

    task automatic apply_mode(input int mode);
        int w, r;
        case (mode)
            0: begin
                if ($urandom_range(0, 3) == 0)      w = int'($urandom_range(0, B - 1));
                else if ($urandom_range(0, 2) == 0) w = int'(B);
                else                                w = int'($urandom_range(B, 511));
                case ($urandom_range(0, 2))
                    0:       r = int'(THR);
                    1:       r = int'(THR) + 1;
                    default: r = int'($urandom_range(0, RD));
                endcase
            end
            1:       begin w = 511; r = 0;       end
            2:       begin w = 511; r = int'(RD); end
            3:       begin w = 0;   r = 0;       end
            default: begin w = 0;   r = int'(RD); end
        endcase
        apply_vals(w, r);
    endtask

    // Controller model: ack a requested burst for B cycles, choose next inputs mid-burst
    task automatic serve(input int mode);
        bit got, is_wr;
        int lat;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (sdram_wr_req || sdram_rd_req) begin
                got = 1'b1;
                break;
            end
        end
        chk("req_seen", int'(got), 1);
        if (!got) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            pend = 1'b0;
            return;
        end
        is_wr = sdram_wr_req;
        lat = int'($urandom_range(0, 3));
        @(negedge clk);
        repeat (lat) @(negedge clk);
        if (is_wr) sdram_wr_ack = 1'b1;
        else       sdram_rd_ack = 1'b1;
        for (int i = 0; i < int'(B); i++) begin
            @(negedge clk);
            if (i == 3) begin
                chk("req_dropped", int'(sdram_wr_req | sdram_rd_req), 0);
                apply_mode(mode);
            end
        end
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
    endtask

    task automatic slot(input int mode);
        if (pend) begin
            serve(mode);
        end else begin
            repeat (12) @(posedge clk);
            #1;
            chk("idle_no_req", int'({sdram_wr_req, sdram_rd_req}), 0);
            @(negedge clk);
            apply_mode(mode);
        end
    endtask

    // Monitor: every new request is matched against the oldest predicted grant
    initial begin
        bit pw, pr;
        exp_t e;
        pw = 1'b0;
        pr = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && ((sdram_wr_req && !pw) || (sdram_rd_req && !pr))) begin
                chk("req_exclusive", int'(sdram_wr_req & sdram_rd_req), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", int'(sdram_wr_req), int'(sdram_rd_req));
                    chk("unexpected_req", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_is_wr", int'(sdram_wr_req), int'(e.is_wr));
                    chk("sys_wraddr",  int'(sys_wraddr),   e.wa);
                    chk("sys_rdaddr",  int'(sys_rdaddr),   e.ra);
                    chk("fill_words",  int'(fill_words),   e.fill);
                end
            end
            pw = sdram_wr_req;
            pr = sdram_rd_req;
        end
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL global_timeout: got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        bit seen;
        int c;
        n_checks = 0;
        n_fail = 0;
        m_wp = 0; m_rp = 0; m_fill = 0; m_last_wr = 1'b0; m_init = 1'b0; pend = 1'b0;
        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        wfifo_used = '0;
        rfifo_used = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_req",  int'(sdram_wr_req), 0);
        chk("rst_rd_req",  int'(sdram_rd_req), 0);
        chk("rst_wraddr",  int'(sys_wraddr), 0);
        chk("rst_rdaddr",  int'(sys_rdaddr), 0);
        chk("rst_fill",    int'(fill_words), 0);
        chk("sdwr_byte",   int'(sdwr_byte), int'(B));
        chk("sdrd_byte",   int'(sdrd_byte), int'(B));
        chk("sched_err",   int'(sched_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Init gating: plenty of write data but controller not ready
        @(negedge clk);
        wfifo_used = UW'(300);
        rfifo_used = UW'(RD);
        seen = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (sdram_wr_req || sdram_rd_req) seen = 1'b1;
        end
        chk("init_gate", int'(seen), 0);
        @(negedge clk);
        sdram_init_done = 1'b1;
        m_init = 1'b1;
        apply_vals(300, int'(RD));
        for (c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (sdram_wr_req) break;
        end
        chk("init_req_latency", c, 2);

        // Fill the ring to full, then confirm writes stay blocked
        slot(2);
        repeat (5) slot(2);
        chk("full_wraddr", int'(sys_wraddr), 0);
        chk("full_fill",   int'(fill_words), int'(MW));

        repeat (3) slot(3);
        repeat (8) slot(1);
        repeat (60) slot(0);

        // Drain to a low fill so a mid-burst reset has something to clear
        while (pend) slot(4);
        while (m_fill > int'(B)) begin
            @(negedge clk);
            apply_vals(0, 0);
            slot(4);
        end
        @(negedge clk);
        apply_vals(511, int'(RD));
        slot(4);
        if (m_wp == 0) begin
            @(negedge clk);
            apply_vals(511, int'(RD));
            slot(4);
        end

        @(negedge clk);
        apply_vals(511, int'(RD));
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            seen = sdram_wr_req;
        end
        chk("rst_test_req", int'(seen), 1);
        @(negedge clk);
        sdram_wr_ack = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_req", int'(sdram_wr_req), 0);
        chk("midrst_wraddr", int'(sys_wraddr), 0);
        chk("midrst_rdaddr", int'(sys_rdaddr), 0);
        chk("midrst_fill",   int'(fill_words), 0);
        chk("midrst_queue",  exp_q.size(), 0);
        sdram_wr_ack = 1'b0;
        exp_q.delete();
        m_wp = 0; m_rp = 0; m_fill = 0; m_last_wr = 1'b0; pend = 1'b0;
        wfifo_used = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        apply_vals(511, int'(RD));
        slot(4);
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_wraddr", int'(sys_wraddr), int'(B));
        chk("post_rst_fill",   int'(fill_words), int'(B));
        chk("sched_err_end",   int'(sched_err), 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
